// File: rtl/hv_cmd_pkg.sv
// Shared definitions for the command dispatcher and host-side CDB tooling:
// CDB layout, opcodes, status codes and the dispatcher state encoding.
package hv_cmd_pkg;

    localparam int CDB_W     = 256;
    localparam int WORD_W    = 32;
    localparam int NUM_WORDS = CDB_W / WORD_W;

    // CDB field offsets (word4 carries the checksum)
    localparam int OPC_LSB  = 0;
    localparam int TAG_LSB  = 8;
    localparam int ADDR_LSB = 32;
    localparam int CSUM_LSB = 128;

    localparam logic [7:0] BSM_WRITE = 8'h40;
    localparam logic [7:0] BSM_READ  = 8'h30;
    localparam logic [7:0] QUERY     = 8'h70;

    localparam logic [7:0] CMD_ST_READ_DONE  = 8'd6;
    localparam logic [7:0] CMD_ST_WRITE_DONE = 8'd7;
    localparam logic [7:0] CMD_ST_READY2FREE = 8'd12;
    localparam logic [7:0] CMD_ST_ERROR      = 8'd15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT_OE,
        ST_COLLECT,
        ST_CHECK,
        ST_ISSUE,
        ST_EXEC,
        ST_REPORT
    } disp_state_e;

    // Only plain data movers reach the engine; QUERY is answered elsewhere.
    function automatic logic opcode_legal(input logic [7:0] opc);
        return (opc == BSM_WRITE) || (opc == BSM_READ);
    endfunction

endpackage

// File: rtl/hv_cdb_checker.sv
// Combinational CDB validation: XOR-fold of all 32-bit words must be zero,
// and the opcode must be one the data engine can execute.
module hv_cdb_checker
    import hv_cmd_pkg::*;
(
    input  logic [CDB_W-1:0] cdb_i,
    output logic             csum_ok_o,
    output logic             op_legal_o,
    output logic [7:0]       opcode_o
);

    logic [WORD_W-1:0] words [NUM_WORDS];
    logic [WORD_W-1:0] fold;

    for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_words
        assign words[gi] = cdb_i[gi*WORD_W +: WORD_W];
    end

    always_comb begin
        fold = '0;
        for (int i = 0; i < NUM_WORDS; i++) begin
            fold = fold ^ words[i];
        end
    end

    assign csum_ok_o  = (fold == '0);
    assign opcode_o   = cdb_i[OPC_LSB +: 8];
    assign op_legal_o = opcode_legal(opcode_o);

endmodule

// File: rtl/hv_cmd_dispatcher.sv
// Pulls one CDB at a time from the command queue, validates it, runs it on the
// data engine and writes the final status back. Single outstanding command.
module hv_cmd_dispatcher
    import hv_cmd_pkg::*;
#(
    parameter int CMD_IO_WIDTH = 64,
    parameter int TIMEOUT_CYC  = 1024,
    parameter int CNT_W        = 11
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cq_cout_ready,
    output logic                    cmd_request,
    input  logic                    cmd_oe,
    input  logic [CMD_IO_WIDTH-1:0] cmd_out,
    output logic                    eng_req,
    output logic                    eng_op,
    output logic [7:0]              eng_tag,
    output logic [31:0]             eng_addr,
    input  logic                    eng_ack,
    input  logic                    eng_done,
    input  logic                    eng_err,
    output logic [7:0]              op_index,
    output logic [7:0]              cmd_op_status,
    output logic                    status_we,
    output logic                    busy,
    output logic                    err_timeout
);

    disp_state_e         state_q, state_d;
    logic [CNT_W-1:0]    tmo_q, tmo_d;
    logic [1:0]          beat_q, beat_d;
    logic [CDB_W-1:0]    cdb_q, cdb_d;
    logic                eng_op_q, eng_op_d;
    logic [7:0]          eng_tag_q, eng_tag_d;
    logic [31:0]         eng_addr_q, eng_addr_d;
    logic [7:0]          op_index_q, op_index_d;
    logic [7:0]          status_q, status_d;
    logic                err_timeout_q, err_timeout_d;

    logic                csum_ok;
    logic                op_legal;
    logic [7:0]          opcode;
    logic [7:0]          done_code;

    hv_cdb_checker u_checker (
        .cdb_i      (cdb_q),
        .csum_ok_o  (csum_ok),
        .op_legal_o (op_legal),
        .opcode_o   (opcode)
    );

    assign done_code = eng_err  ? CMD_ST_ERROR :
                       eng_op_q ? CMD_ST_WRITE_DONE : CMD_ST_READ_DONE;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            tmo_q         <= '0;
            beat_q        <= '0;
            cdb_q         <= '0;
            eng_op_q      <= 1'b0;
            eng_tag_q     <= '0;
            eng_addr_q    <= '0;
            op_index_q    <= '0;
            status_q      <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            tmo_q         <= tmo_d;
            beat_q        <= beat_d;
            cdb_q         <= cdb_d;
            eng_op_q      <= eng_op_d;
            eng_tag_q     <= eng_tag_d;
            eng_addr_q    <= eng_addr_d;
            op_index_q    <= op_index_d;
            status_q      <= status_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        tmo_d         = tmo_q;
        beat_d        = beat_q;
        cdb_d         = cdb_q;
        eng_op_d      = eng_op_q;
        eng_tag_d     = eng_tag_q;
        eng_addr_d    = eng_addr_q;
        op_index_d    = op_index_q;
        status_d      = status_q;
        err_timeout_d = err_timeout_q;

        case (state_q)
            ST_IDLE: begin
                if (cq_cout_ready) state_d = ST_REQ;
            end
            ST_REQ: begin
                tmo_d   = '0;
                state_d = ST_WAIT_OE;
            end
            ST_WAIT_OE: begin
                if (cmd_oe) begin
                    cdb_d[CMD_IO_WIDTH-1:0] = cmd_out;
                    beat_d  = 2'd1;
                    state_d = ST_COLLECT;
                end else if (tmo_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    // Queue never answered: flag it and drop the request silently.
                    err_timeout_d = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_COLLECT: begin
                if (cmd_oe) begin
                    cdb_d[beat_q*CMD_IO_WIDTH +: CMD_IO_WIDTH] = cmd_out;
                    if (beat_q == 2'd3) state_d = ST_CHECK;
                    else                beat_d  = beat_q + 2'd1;
                end else begin
                    op_index_d = cdb_q[TAG_LSB +: 8];
                    status_d   = CMD_ST_ERROR;
                    state_d    = ST_REPORT;
                end
            end
            ST_CHECK: begin
                if (csum_ok && op_legal) begin
                    eng_op_d   = (opcode == BSM_WRITE);
                    eng_tag_d  = cdb_q[TAG_LSB +: 8];
                    eng_addr_d = cdb_q[ADDR_LSB +: 32];
                    state_d    = ST_ISSUE;
                end else begin
                    op_index_d = cdb_q[TAG_LSB +: 8];
                    status_d   = CMD_ST_ERROR;
                    state_d    = ST_REPORT;
                end
            end
            ST_ISSUE: begin
                // A completion arriving together with the ack must not be lost.
                if (eng_ack) begin
                    if (eng_done) begin
                        op_index_d = eng_tag_q;
                        status_d   = done_code;
                        state_d    = ST_REPORT;
                    end else begin
                        state_d = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                if (eng_done) begin
                    op_index_d = eng_tag_q;
                    status_d   = done_code;
                    state_d    = ST_REPORT;
                end
            end
            ST_REPORT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign cmd_request   = (state_q == ST_REQ);
    assign eng_req       = (state_q == ST_ISSUE);
    assign status_we     = (state_q == ST_REPORT);
    assign busy          = (state_q != ST_IDLE);
    assign eng_op        = eng_op_q;
    assign eng_tag       = eng_tag_q;
    assign eng_addr      = eng_addr_q;
    assign op_index      = op_index_q;
    assign cmd_op_status = status_q;
    assign err_timeout   = err_timeout_q;

endmodule

// File: tb/tb_hv_cmd_dispatcher.sv
// Directed bench for hv_cmd_dispatcher: normal write/read flows, checksum and
// opcode rejection, burst abort, queue timeout and reset mid-operation.
module tb_hv_cmd_dispatcher;

    localparam int TMO = 1024;

    logic        clk;
    logic        reset;
    logic        cq_cout_ready;
    logic        cmd_request;
    logic        cmd_oe;
    logic [63:0] cmd_out;
    logic        eng_req;
    logic        eng_op;
    logic [7:0]  eng_tag;
    logic [31:0] eng_addr;
    logic        eng_ack;
    logic        eng_done;
    logic        eng_err;
    logic [7:0]  op_index;
    logic [7:0]  cmd_op_status;
    logic        status_we;
    logic        busy;
    logic        err_timeout;

    int errors = 0;
    int checks = 0;

    hv_cmd_dispatcher #(
        .CMD_IO_WIDTH (64),
        .TIMEOUT_CYC  (TMO),
        .CNT_W        (11)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cq_cout_ready (cq_cout_ready),
        .cmd_request   (cmd_request),
        .cmd_oe        (cmd_oe),
        .cmd_out       (cmd_out),
        .eng_req       (eng_req),
        .eng_op        (eng_op),
        .eng_tag       (eng_tag),
        .eng_addr      (eng_addr),
        .eng_ack       (eng_ack),
        .eng_done      (eng_done),
        .eng_err       (eng_err),
        .op_index      (op_index),
        .cmd_op_status (cmd_op_status),
        .status_we     (status_we),
        .busy          (busy),
        .err_timeout   (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [255:0] build_cdb(input logic [7:0] opc, input logic [7:0] tag,
                                               input logic [31:0] addr);
        logic [255:0] c;
        c = '0;
        c[7:0]     = opc;
        c[15:8]    = tag;
        c[31:16]   = 16'hA5C3;
        c[63:32]   = addr;
        c[95:64]   = 32'h1234_5678;
        c[127:96]  = 32'hDEAD_BEEF;
        c[191:160] = 32'h0F0F_00FF;
        c[223:192] = {tag, 24'h13579B};
        c[255:224] = 32'hCAFE_0001;
        c[159:128] = c[31:0] ^ c[63:32] ^ c[95:64] ^ c[127:96] ^ c[191:160] ^ c[223:192] ^ c[255:224];
        return c;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns with the DUT in CHECK (last beat just sampled).
    task automatic send_cdb(input logic [255:0] c);
        cq_cout_ready = 1'b1;
        tick();
        cq_cout_ready = 1'b0;
        checks++;
        if (cmd_request !== 1'b1) begin
            errors++;
            $display("FAIL cmd_request_latency: got %b want 1", cmd_request);
        end
        tick();
        checks++;
        if (cmd_request !== 1'b0) begin
            errors++;
            $display("FAIL cmd_request_pulse: got %b want 0", cmd_request);
        end
        for (int b = 0; b < 4; b++) begin
            cmd_oe  = 1'b1;
            cmd_out = c[b*64 +: 64];
            tick();
        end
        cmd_oe  = 1'b0;
        cmd_out = '0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #3;
        checks++;
        if ({cmd_request, eng_req, eng_op, eng_tag, eng_addr, op_index, cmd_op_status,
             status_we, busy, err_timeout} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b req=%b tag=%0h idx=%0h st=%0h want all 0",
                     busy, eng_req, eng_tag, op_index, cmd_op_status);
        end
        @(posedge clk);
        @(posedge clk);
        #3;
        reset = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || cmd_request !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle: got busy=%b cmd_request=%b want 0 0", busy, cmd_request);
        end
        $display("txn reset: busy=%b err_timeout=%b", busy, err_timeout);
    endtask

    task automatic test_write_back_to_back();
        for (int t = 0; t < 3; t++) begin
            send_cdb(build_cdb(8'h40, 8'(t), 32'h100 + t));
            tick();
            checks++;
            if (eng_req !== 1'b1 || eng_op !== 1'b1 || eng_tag !== 8'(t)) begin
                errors++;
                $display("FAIL write_issue[%0d]: got req=%b op=%b tag=%0h want 1 1 %0h",
                         t, eng_req, eng_op, eng_tag, t);
            end
            repeat (5) tick();
            checks++;
            if (eng_req !== 1'b1) begin
                errors++;
                $display("FAIL write_req_held[%0d]: got %b want 1", t, eng_req);
            end
            eng_ack  = 1'b1;
            eng_done = 1'b1;
            tick();
            eng_ack  = 1'b0;
            eng_done = 1'b0;
            checks++;
            if (status_we !== 1'b1 || op_index !== 8'(t) || cmd_op_status !== 8'd7) begin
                errors++;
                $display("FAIL write_status[%0d]: got we=%b idx=%0h st=%0d want 1 %0h 7",
                         t, status_we, op_index, cmd_op_status, t);
            end
            $display("txn write tag=%0d: we=%b idx=%0h status=%0d", t, status_we, op_index, cmd_op_status);
            tick();
            checks++;
            if (status_we !== 1'b0 || busy !== 1'b0 || op_index !== 8'(t)) begin
                errors++;
                $display("FAIL write_after_report[%0d]: got we=%b busy=%b idx=%0h want 0 0 %0h",
                         t, status_we, busy, op_index, t);
            end
        end
    endtask

    task automatic test_read();
        send_cdb(build_cdb(8'h30, 8'd5, 32'h0000_1000));
        tick();
        checks++;
        if (eng_req !== 1'b1 || eng_op !== 1'b0 || eng_addr !== 32'h1000 || eng_tag !== 8'd5) begin
            errors++;
            $display("FAIL read_issue: got req=%b op=%b addr=%0h tag=%0h want 1 0 1000 5",
                     eng_req, eng_op, eng_addr, eng_tag);
        end
        eng_ack = 1'b1;
        tick();
        eng_ack = 1'b0;
        checks++;
        if (eng_req !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL read_exec: got req=%b busy=%b want 0 1", eng_req, busy);
        end
        tick();
        tick();
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        checks++;
        if (status_we !== 1'b1 || op_index !== 8'd5 || cmd_op_status !== 8'd6) begin
            errors++;
            $display("FAIL read_status: got we=%b idx=%0h st=%0d want 1 5 6", status_we, op_index, cmd_op_status);
        end
        $display("txn read tag=5: we=%b idx=%0h status=%0d", status_we, op_index, cmd_op_status);
        tick();
    endtask

    task automatic test_eng_err();
        send_cdb(build_cdb(8'h40, 8'h11, 32'h4000));
        tick();
        eng_ack = 1'b1;
        tick();
        eng_ack  = 1'b0;
        eng_done = 1'b1;
        eng_err  = 1'b1;
        tick();
        eng_done = 1'b0;
        eng_err  = 1'b0;
        checks++;
        if (status_we !== 1'b1 || op_index !== 8'h11 || cmd_op_status !== 8'd15) begin
            errors++;
            $display("FAIL eng_err_status: got we=%b idx=%0h st=%0d want 1 11 15", status_we, op_index, cmd_op_status);
        end
        $display("txn engine error tag=0x11: idx=%0h status=%0d", op_index, cmd_op_status);
        tick();
    endtask

    task automatic test_rejected(input logic [255:0] c, input logic [7:0] tag, input string nm);
        send_cdb(c);
        checks++;
        if (eng_req !== 1'b0) begin
            errors++;
            $display("FAIL %s_no_req_check: got %b want 0", nm, eng_req);
        end
        tick();
        checks++;
        if (eng_req !== 1'b0 || status_we !== 1'b1 || op_index !== tag || cmd_op_status !== 8'd15) begin
            errors++;
            $display("FAIL %s_status: got req=%b we=%b idx=%0h st=%0d want 0 1 %0h 15",
                     nm, eng_req, status_we, op_index, cmd_op_status, tag);
        end
        $display("txn %s tag=%0h: we=%b status=%0d", nm, tag, status_we, cmd_op_status);
        tick();
    endtask

    task automatic test_bad_checksum();
        logic [255:0] c;
        c = build_cdb(8'h40, 8'h09, 32'h2000);
        c[135:128] = ~c[135:128];
        test_rejected(c, 8'h09, "bad_checksum");
    endtask

    task automatic test_query();
        test_rejected(build_cdb(8'h70, 8'h22, 32'h3000), 8'h22, "query");
    endtask

    task automatic test_collect_abort();
        logic [255:0] c;
        c = build_cdb(8'h40, 8'h3C, 32'h5000);
        cq_cout_ready = 1'b1;
        tick();
        cq_cout_ready = 1'b0;
        tick();
        for (int b = 0; b < 2; b++) begin
            cmd_oe  = 1'b1;
            cmd_out = c[b*64 +: 64];
            tick();
        end
        cmd_oe  = 1'b0;
        cmd_out = '0;
        tick();
        checks++;
        if (status_we !== 1'b1 || op_index !== 8'h3C || cmd_op_status !== 8'd15 || eng_req !== 1'b0) begin
            errors++;
            $display("FAIL collect_abort: got we=%b idx=%0h st=%0d req=%b want 1 3c 15 0",
                     status_we, op_index, cmd_op_status, eng_req);
        end
        $display("txn collect abort tag=3c: idx=%0h status=%0d", op_index, cmd_op_status);
        tick();
    endtask

    task automatic test_timeout();
        int  n;
        logic we_seen;
        n       = 0;
        we_seen = 1'b0;
        cq_cout_ready = 1'b1;
        tick();
        cq_cout_ready = 1'b0;
        while (err_timeout !== 1'b1 && n < TMO + 20) begin
            tick();
            n++;
            if (status_we === 1'b1) we_seen = 1'b1;
        end
        checks++;
        if (err_timeout !== 1'b1 || n != TMO + 1) begin
            errors++;
            $display("FAIL timeout_cycles: got err=%b after %0d cycles want 1 after %0d", err_timeout, n, TMO + 1);
        end
        checks++;
        if (busy !== 1'b0 || we_seen !== 1'b0) begin
            errors++;
            $display("FAIL timeout_idle: got busy=%b status_we_seen=%b want 0 0", busy, we_seen);
        end
        repeat (3) tick();
        checks++;
        if (err_timeout !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sticky: got %b want 1", err_timeout);
        end
        $display("txn timeout: err_timeout=%b after %0d cycles", err_timeout, n);
    endtask

    task automatic test_reset_exec();
        send_cdb(build_cdb(8'h40, 8'h04, 32'h6000));
        tick();
        eng_ack = 1'b1;
        tick();
        eng_ack = 1'b0;
        checks++;
        if (busy !== 1'b1 || eng_tag !== 8'h04) begin
            errors++;
            $display("FAIL reset_exec_pre: got busy=%b tag=%0h want 1 4", busy, eng_tag);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({cmd_request, eng_req, eng_op, eng_tag, eng_addr, op_index, cmd_op_status,
             status_we, busy, err_timeout} !== '0) begin
            errors++;
            $display("FAIL reset_exec_outputs: got busy=%b tag=%0h addr=%0h idx=%0h st=%0h err=%b want all 0",
                     busy, eng_tag, eng_addr, op_index, cmd_op_status, err_timeout);
        end
        #2;
        reset = 1'b1;
        tick();
        send_cdb(build_cdb(8'h40, 8'h06, 32'h7000));
        tick();
        eng_ack = 1'b1;
        tick();
        eng_ack  = 1'b0;
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        checks++;
        if (status_we !== 1'b1 || op_index !== 8'h06 || cmd_op_status !== 8'd7) begin
            errors++;
            $display("FAIL post_reset_write: got we=%b idx=%0h st=%0d want 1 6 7", status_we, op_index, cmd_op_status);
        end
        $display("txn post-reset write tag=6: idx=%0h status=%0d", op_index, cmd_op_status);
        tick();
    endtask

    initial begin
        cq_cout_ready = 1'b0;
        cmd_oe        = 1'b0;
        cmd_out       = '0;
        eng_ack       = 1'b0;
        eng_done      = 1'b0;
        eng_err       = 1'b0;
        test_reset();
        test_write_back_to_back();
        test_read();
        test_eng_err();
        test_bad_checksum();
        test_query();
        test_collect_abort();
        test_timeout();
        test_reset_exec();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
